// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the SNN conv window scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_A = 3'd1,
        ST_DRAIN_A = 3'd2,
        ST_ISSUE_B = 3'd3,
        ST_DRAIN_B = 3'd4,
        ST_DONE    = 3'd5
    } snn_sched_state_t;

    localparam int IMG_DIM_DEF = 6;
    localparam int KER_DIM_DEF = 3;

    // Coordinate fields are sized for the largest supported output grid;
    // users slice down to their own coordinate width.
    localparam int COORD_W_MAX = 8;

    typedef struct packed {
        logic                   sel;
        logic [COORD_W_MAX-1:0] row;
        logic [COORD_W_MAX-1:0] col;
    } snn_win_t;

    function automatic int out_dim(input int img_dim, input int ker_dim);
        return img_dim - ker_dim + 1;
    endfunction

    // Never return zero width, even for a 1x1 output grid.
    function automatic int coord_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/snn_raster_cnt.sv
// Row/column raster counter over a DIM x DIM grid, wraps to (0,0) after the last cell.
// Latency: position updates on the clock edge after i_adv.
// Backpressure: none; advances only when the owner asserts i_adv.
module snn_raster_cnt
    import snn_pkg::*;
#(
    parameter int DIM = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_adv,
    output logic [W-1:0] o_row,
    output logic [W-1:0] o_col,
    output logic         o_last
);

    localparam logic [W-1:0] LAST = W'(DIM - 1);

    logic [W-1:0] r_row;
    logic [W-1:0] r_col;

    // Raster step: column first, row on column wrap, both wrap after the last cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (r_col == LAST) begin
                r_col <= '0;
                r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == LAST) && (r_col == LAST);

endmodule

// File: rtl/snn_conv_sched.sv
// Window scheduler: walks all kernel positions of image A then B, credit-limited issue, result coordinates.
// Latency: win_valid combinational from registered state/counters; one window per cycle with prompt results.
// Backpressure: win_valid holds stable payload until win_ready; issue stalls at MAX_OUT in flight or buffer not ready.
// Optional: SNN_SCHED_PERF_EN adds stall_cycles / job_cycles performance counters.
module snn_conv_sched
    import snn_pkg::*;
#(
    parameter int IMG_DIM = IMG_DIM_DEF,
    parameter int KER_DIM = KER_DIM_DEF,
    parameter int MAX_OUT = 2,
    localparam int OUT_DIM = out_dim(IMG_DIM, KER_DIM),
    localparam int CW      = coord_w(OUT_DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    buf_rdy,
    output logic          win_valid,
    input  logic          win_ready,
    output logic          win_sel,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    input  logic          res_valid,
    output logic          res_wr_en,
    output logic          res_wr_sel,
    output logic [CW-1:0] res_wr_row,
    output logic [CW-1:0] res_wr_col,
    output logic          busy,
    output logic          done,
`ifdef SNN_SCHED_PERF_EN
    output logic [15:0]   stall_cycles,
    output logic [15:0]   job_cycles,
`endif
    output logic          err
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] OUT_LIM = OW'(MAX_OUT);

    snn_sched_state_t r_state;
    snn_sched_state_t w_state_nxt;

    logic [OW-1:0] r_outst;
    logic          r_err;
    logic          r_res_sel;

    logic          w_issuing;
    logic          w_img_rdy;
    logic          w_win_vld;
    logic          w_hs;
    logic          w_res_acc;
    logic [CW-1:0] w_iss_row;
    logic [CW-1:0] w_iss_col;
    logic          w_iss_last;
    logic [CW-1:0] w_res_row;
    logic [CW-1:0] w_res_col;
    logic          w_res_last;
    snn_win_t      w_iss_win;
    snn_win_t      w_res_win;

    assign w_issuing = (r_state == ST_ISSUE_A) || (r_state == ST_ISSUE_B);
    assign w_img_rdy = (r_state == ST_ISSUE_B) ? buf_rdy[1] : buf_rdy[0];
    assign w_win_vld = w_issuing && w_img_rdy && (r_outst < OUT_LIM);
    assign w_hs      = w_win_vld && win_ready;
    // A result with nothing in flight is a protocol error and is dropped.
    assign w_res_acc = res_valid && (r_outst != '0);

    snn_raster_cnt #(.DIM(OUT_DIM), .W(CW)) u_iss_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_adv  (w_hs),
        .o_row  (w_iss_row),
        .o_col  (w_iss_col),
        .o_last (w_iss_last)
    );

    snn_raster_cnt #(.DIM(OUT_DIM), .W(CW)) u_res_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_adv  (w_res_acc),
        .o_row  (w_res_row),
        .o_col  (w_res_col),
        .o_last (w_res_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: issue phase ends on the last handshake, drain waits for all results back.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_ISSUE_A;
            ST_ISSUE_A: if (w_hs && w_iss_last) w_state_nxt = ST_DRAIN_A;
            ST_DRAIN_A: if (r_outst == '0) w_state_nxt = ST_ISSUE_B;
            ST_ISSUE_B: if (w_hs && w_iss_last) w_state_nxt = ST_DRAIN_B;
            ST_DRAIN_B: if (r_outst == '0) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // In-flight credit count: issue adds, accepted result removes, both together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= '0;
        end else begin
            case ({w_hs, w_res_acc})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Sticky error on an unexpected result; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (res_valid && (r_outst == '0)) begin
            r_err <= 1'b1;
        end
    end

    // Result image select flips after the last cell of each image, so B wraps back to A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_sel <= 1'b0;
        end else if (w_res_acc && w_res_last) begin
            r_res_sel <= ~r_res_sel;
        end
    end

    // Pack issue and result coordinates into the shared window struct.
    always_comb begin
        w_iss_win     = '0;
        w_iss_win.sel = (r_state == ST_ISSUE_B) || (r_state == ST_DRAIN_B);
        w_iss_win.row = COORD_W_MAX'(w_iss_row);
        w_iss_win.col = COORD_W_MAX'(w_iss_col);
        w_res_win     = '0;
        w_res_win.sel = r_res_sel;
        w_res_win.row = COORD_W_MAX'(w_res_row);
        w_res_win.col = COORD_W_MAX'(w_res_col);
    end

    assign win_valid  = w_win_vld;
    assign win_sel    = w_iss_win.sel;
    assign win_row    = w_iss_win.row[CW-1:0];
    assign win_col    = w_iss_win.col[CW-1:0];
    assign res_wr_en  = w_res_acc;
    assign res_wr_sel = w_res_win.sel;
    assign res_wr_row = w_res_win.row[CW-1:0];
    assign res_wr_col = w_res_win.col[CW-1:0];
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;

`ifdef SNN_SCHED_PERF_EN
    logic [15:0] r_stall_cyc;
    logic [15:0] r_job_cyc;

    // Saturating stall/job counters, cleared by an accepted start, frozen while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cyc <= '0;
            r_job_cyc   <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stall_cyc <= '0;
            r_job_cyc   <= '0;
        end else begin
            if (w_issuing && !w_hs && (r_stall_cyc != 16'hFFFF)) begin
                r_stall_cyc <= r_stall_cyc + 16'd1;
            end
            if ((r_state != ST_IDLE) && (r_job_cyc != 16'hFFFF)) begin
                r_job_cyc <= r_job_cyc + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cyc;
    assign job_cycles   = r_job_cyc;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_snn_conv_sched.sv
// Bench for snn_conv_sched: scoreboard of issued windows checked against returned result coordinates.
// Latency: results returned by the bench one cycle after issue when auto-return is on.
// Backpressure: bench drives win_ready / buf_rdy stalls and withholds results to exercise credit limit.
module tb_snn_conv_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] buf_rdy;
    logic       win_valid;
    logic       win_ready;
    logic       win_sel;
    logic [1:0] win_row;
    logic [1:0] win_col;
    logic       res_valid;
    logic       res_wr_en;
    logic       res_wr_sel;
    logic [1:0] res_wr_row;
    logic [1:0] res_wr_col;
    logic       busy;
    logic       done;
    logic       err;
`ifdef SNN_SCHED_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] job_cycles;
`endif

    snn_conv_sched #(.IMG_DIM(6), .KER_DIM(3), .MAX_OUT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .buf_rdy    (buf_rdy),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_sel    (win_sel),
        .win_row    (win_row),
        .win_col    (win_col),
        .res_valid  (res_valid),
        .res_wr_en  (res_wr_en),
        .res_wr_sel (res_wr_sel),
        .res_wr_row (res_wr_row),
        .res_wr_col (res_wr_col),
        .busy       (busy),
        .done       (done),
`ifdef SNN_SCHED_PERF_EN
        .stall_cycles (stall_cycles),
        .job_cycles   (job_cycles),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [4:0] resq[$];
    logic       exp_sel;
    int         exp_row;
    int         exp_col;
    bit         auto_res;
    int         n_hs;
    int         n_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_sel = 1'b0;
        exp_row = 0;
        exp_col = 0;
        resq.delete();
    endtask

    // One clock cycle; entered at a falling edge with inputs set, leaves at the next falling edge.
    task automatic cyc();
        logic       hs;
        logic       rv;
        logic [4:0] e;
        rv = auto_res && (resq.size() > 0);
        res_valid = rv;
        #1;
        hs = win_valid && win_ready;
        if (rv) begin
            e = resq.pop_front();
            chk("res_en",  32'(res_wr_en),  32'd1);
            chk("res_sel", 32'(res_wr_sel), 32'(e[4]));
            chk("res_row", 32'(res_wr_row), 32'(e[3:2]));
            chk("res_col", 32'(res_wr_col), 32'(e[1:0]));
        end
        if (hs) begin
            chk("win_sel", 32'(win_sel), 32'(exp_sel));
            chk("win_row", 32'(win_row), 32'(exp_row));
            chk("win_col", 32'(win_col), 32'(exp_col));
            resq.push_back({exp_sel, 2'(exp_row), 2'(exp_col)});
            n_hs++;
            exp_col++;
            if (exp_col == 4) begin
                exp_col = 0;
                exp_row++;
                if (exp_row == 4) begin
                    exp_row = 0;
                    exp_sel = ~exp_sel;
                end
            end
        end
        if (done) n_done++;
        @(negedge clk);
    endtask

    task automatic start_job();
        n_hs  = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int k;
        int d0;
        k  = 0;
        d0 = n_done;
        while ((n_done == d0) && (k < budget)) begin
            cyc();
            k++;
        end
        if (n_done == d0) chk("timeout_done", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int hs0;
        rst_n     = 1'b0;
        start     = 1'b0;
        buf_rdy   = 2'b00;
        win_ready = 1'b0;
        res_valid = 1'b0;
        auto_res  = 1'b0;
        n_hs      = 0;
        n_done    = 0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_res_en",    32'(res_wr_en), 32'd0);
        chk("rst_win_row",   32'(win_row),   32'd0);
        chk("rst_res_sel",   32'(res_wr_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full run, no stalls, prompt results
        buf_rdy   = 2'b11;
        win_ready = 1'b1;
        auto_res  = 1'b1;
        n_done    = 0;
        start_job();
        run_to_done(200);
        repeat (5) cyc();
        chk("t1_hs",    32'(n_hs),   32'd32);
        chk("t1_done",  32'(n_done), 32'd1);
        chk("t1_err",   32'(err),    32'd0);
        chk("t1_busy",  32'(busy),   32'd0);
        chk("t1_q",     32'(resq.size()), 32'd0);
`ifdef SNN_SCHED_PERF_EN
        chk("t1_stall", 32'(stall_cycles), 32'd0);
        chk("t1_job",   32'(job_cycles),   32'd37);
`endif

        // win_ready held low on A(1,2)
        n_done = 0;
        start_job();
        k = 0;
        while (!((exp_sel == 1'b0) && (exp_row == 1) && (exp_col == 2)) && (k < 100)) begin
            cyc();
            k++;
        end
        win_ready = 1'b0;
        hs0 = n_hs;
        repeat (5) begin
            cyc();
            #1;
            chk("t2_vld", 32'(win_valid), 32'd1);
            chk("t2_sel", 32'(win_sel),   32'd0);
            chk("t2_row", 32'(win_row),   32'd1);
            chk("t2_col", 32'(win_col),   32'd2);
        end
        chk("t2_noadv", 32'(n_hs), 32'(hs0));
        win_ready = 1'b1;
        run_to_done(200);
        chk("t2_hs",   32'(n_hs),   32'd32);
        chk("t2_done", 32'(n_done), 32'd1);

        // Credit limit: no results returned
        auto_res = 1'b0;
        n_done   = 0;
        start_job();
        repeat (10) cyc();
        chk("t3_hs2", 32'(n_hs), 32'd2);
        #1;
        chk("t3_vld0", 32'(win_valid), 32'd0);
        auto_res = 1'b1;
        run_to_done(200);
        chk("t3_hs",   32'(n_hs),   32'd32);
        chk("t3_done", 32'(n_done), 32'd1);

        // Image B buffer not ready
        buf_rdy = 2'b01;
        n_done  = 0;
        start_job();
        k = 0;
        while (!((exp_sel == 1'b1) && (resq.size() == 0)) && (k < 100)) begin
            cyc();
            k++;
        end
        repeat (10) cyc();
        #1;
        chk("t4_vld0", 32'(win_valid), 32'd0);
        chk("t4_busy", 32'(busy),      32'd1);
        chk("t4_sel",  32'(win_sel),   32'd1);
        chk("t4_hs16", 32'(n_hs),      32'd16);
        buf_rdy = 2'b11;
        run_to_done(200);
        chk("t4_hs",   32'(n_hs),   32'd32);
        chk("t4_done", 32'(n_done), 32'd1);

        // Unexpected result while idle
        res_valid = 1'b1;
        #1;
        chk("t5_en0", 32'(res_wr_en), 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        chk("t5_err", 32'(err), 32'd1);
        @(negedge clk);
        n_done = 0;
        start_job();
        run_to_done(200);
        chk("t5_hs",     32'(n_hs), 32'd32);
        chk("t5_sticky", 32'(err),  32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_clr", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-job after 7 issues
        n_done = 0;
        start_job();
        k = 0;
        while ((n_hs < 7) && (k < 50)) begin
            cyc();
            k++;
        end
        rst_n     = 1'b0;
        res_valid = 1'b0;
        #1;
        chk("t6_vld",  32'(win_valid),  32'd0);
        chk("t6_busy", 32'(busy),       32'd0);
        chk("t6_done", 32'(done),       32'd0);
        chk("t6_err",  32'(err),        32'd0);
        chk("t6_en",   32'(res_wr_en),  32'd0);
        chk("t6_row",  32'(win_row),    32'd0);
        chk("t6_col",  32'(win_col),    32'd0);
        chk("t6_rrow", 32'(res_wr_row), 32'd0);
        chk("t6_rcol", 32'(res_wr_col), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_nodone", 32'(n_done), 32'd0);
        start_job();
        run_to_done(200);
        chk("t6_hs",   32'(n_hs),   32'd32);
        chk("t6_done1", 32'(n_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
